// File: rtl/ecc_serial_loader_pkg.sv
// ECC serial loader shared definitions:
// operand sizes, width codes, FSM states.
package ecc_serial_loader_pkg;

  localparam int MAX_BITS = 128;
  localparam int CNT_W    = 8;

  localparam logic [1:0] BITS16  = 2'b00;
  localparam logic [1:0] BITS32  = 2'b01;
  localparam logic [1:0] BITS64  = 2'b10;
  localparam logic [1:0] BITS128 = 2'b11;

  typedef enum logic [2:0] {
    MP_IDLE,
    MP_MODE_HI,
    MP_MODE_LO,
    MP_LOAD,
    MP_DONE
  } mp_state_t;

  typedef enum logic [1:0] {
    NP_IDLE,
    NP_LOAD,
    NP_DONE
  } np_state_t;

  function automatic logic [CNT_W-1:0] width_to_nbits(
    input logic [1:0] w
  );
    logic [CNT_W-1:0] n;
    n = CNT_W'(16);
    unique case (w)
      BITS16:  n = CNT_W'(16);
      BITS32:  n = CNT_W'(32);
      BITS64:  n = CNT_W'(64);
      BITS128: n = CNT_W'(128);
      default: n = CNT_W'(16);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ecc_serial_loader_if.sv
// ECC serial loader bus: serial operand inputs,
// parallel operand outputs and core handshake.
interface ecc_serial_loader_if;
  import ecc_serial_loader_pkg::*;

  logic                i_m_P_valid;
  logic                i_mode;
  logic                i_a;
  logic                i_prime;
  logic                i_Px;
  logic                i_Py;
  logic                i_m;
  logic                i_nP_valid;
  logic                i_nPx;
  logic                i_nPy;
  logic                i_core_ack;
  logic                o_op_valid;
  logic [1:0]          o_width;
  logic [CNT_W-1:0]    o_nbits;
  logic [MAX_BITS-1:0] o_a;
  logic [MAX_BITS-1:0] o_prime;
  logic [MAX_BITS-1:0] o_Px;
  logic [MAX_BITS-1:0] o_Py;
  logic [MAX_BITS-1:0] o_m;
  logic [MAX_BITS-1:0] o_nPx;
  logic [MAX_BITS-1:0] o_nPy;
  logic                o_err;

  modport slave (
    input  i_m_P_valid, i_mode, i_a, i_prime,
    input  i_Px, i_Py, i_m,
    input  i_nP_valid, i_nPx, i_nPy, i_core_ack,
    output o_op_valid, o_width, o_nbits,
    output o_a, o_prime, o_Px, o_Py, o_m,
    output o_nPx, o_nPy, o_err
  );

  modport master (
    output i_m_P_valid, i_mode, i_a, i_prime,
    output i_Px, i_Py, i_m,
    output i_nP_valid, i_nPx, i_nPy, i_core_ack,
    input  o_op_valid, o_width, o_nbits,
    input  o_a, o_prime, o_Px, o_Py, o_m,
    input  o_nPx, o_nPy, o_err
  );

endinterface

// File: rtl/ecc_sipo_chan.sv
// Multi-lane MSB-first deserializer with a
// shared down-counter; done flags the last bit.
module ecc_sipo_chan #(
  parameter int LANES = 1,
  parameter int W     = 128,
  parameter int CW    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic [CW-1:0]             count,
  input  logic                      shift,
  input  logic [LANES-1:0]          din,
  output logic                      done,
  output logic [LANES-1:0][W-1:0]   data
);

  logic [CW-1:0] cnt;

  // bits remaining in the current load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= count;
    end else if (shift) begin
      cnt <= cnt - 1'b1;
    end
  end

  // lane registers: clear, then shift in from the LSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (clr) begin
      data <= '0;
    end else if (shift) begin
      for (int l = 0; l < LANES; l++) begin
        data[l] <= {data[l][W-2:0], din[l]};
      end
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/ecc_serial_loader.sv
// ECC serial loader top: width FSM, nP accept
// gating, operand handshake and error flag.
module ecc_serial_loader
  import ecc_serial_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ecc_serial_loader_if.slave bus
);

  mp_state_t mp_q, mp_d;
  np_state_t np_q, np_d;

  logic [4:0][MAX_BITS-1:0] mp_data;
  logic [1:0][MAX_BITS-1:0] np_data;
  logic                     mp_done;
  logic                     np_done;
  logic [1:0]               width_q;
  logic [CNT_W-1:0]         nbits_q;
  logic                     valid_q;
  logic                     err_q;

  logic ack_take;
  logic width_known;
  logic np_try;
  logic np_accept;
  logic np_drop;
  logic mp_clr;

  assign ack_take    = bus.i_core_ack & valid_q;
  assign width_known = (mp_q == MP_LOAD) |
                       (mp_q == MP_DONE);
  assign np_try      = bus.i_nP_valid &
                       (np_q == NP_IDLE);
  assign np_accept   = np_try & width_known;
  assign np_drop     = np_try & ~width_known;
  assign mp_clr      = bus.i_m_P_valid &
                       (mp_q == MP_IDLE);

  // mP channel next state
  always_comb begin
    mp_d = mp_q;
    unique case (mp_q)
      MP_IDLE:    if (bus.i_m_P_valid) mp_d = MP_MODE_HI;
      MP_MODE_HI: mp_d = MP_MODE_LO;
      MP_MODE_LO: mp_d = MP_LOAD;
      MP_LOAD:    if (mp_done) mp_d = MP_DONE;
      MP_DONE:    if (ack_take) mp_d = MP_IDLE;
      default:    mp_d = MP_IDLE;
    endcase
  end

  // nP channel next state
  always_comb begin
    np_d = np_q;
    unique case (np_q)
      NP_IDLE: if (np_accept) np_d = NP_LOAD;
      NP_LOAD: if (np_done) np_d = NP_DONE;
      NP_DONE: if (ack_take) np_d = NP_IDLE;
      default: np_d = NP_IDLE;
    endcase
  end

  // state registers for both channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp_q <= MP_IDLE;
      np_q <= NP_IDLE;
    end else begin
      mp_q <= mp_d;
      np_q <= np_d;
    end
  end

  // width code capture and decoded bit count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q <= '0;
      nbits_q <= '0;
    end else begin
      if (mp_q == MP_MODE_HI) begin
        width_q[1] <= bus.i_mode;
      end
      if (mp_q == MP_MODE_LO) begin
        width_q[0] <= bus.i_mode;
        nbits_q    <= width_to_nbits(
                        {width_q[1], bus.i_mode});
      end
    end
  end

  // operands valid while both channels hold data;
  // sticky error on a strobe before the width is known
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= (mp_d == MP_DONE) &&
                 (np_d == NP_DONE);
      err_q   <= err_q | np_drop;
    end
  end

  ecc_sipo_chan #(
    .LANES (5),
    .W     (MAX_BITS),
    .CW    (CNT_W)
  ) u_mp (
    .clk   (clk),
    .rst   (rst),
    .clr   (mp_clr),
    .start (mp_q == MP_MODE_LO),
    .count (width_to_nbits({width_q[1], bus.i_mode})),
    .shift (mp_q == MP_LOAD),
    .din   ({bus.i_m, bus.i_Py, bus.i_Px,
             bus.i_prime, bus.i_a}),
    .done  (mp_done),
    .data  (mp_data)
  );

  ecc_sipo_chan #(
    .LANES (2),
    .W     (MAX_BITS),
    .CW    (CNT_W)
  ) u_np (
    .clk   (clk),
    .rst   (rst),
    .clr   (np_accept),
    .start (np_accept),
    .count (nbits_q),
    .shift (np_q == NP_LOAD),
    .din   ({bus.i_nPy, bus.i_nPx}),
    .done  (np_done),
    .data  (np_data)
  );

  assign bus.o_op_valid = valid_q;
  assign bus.o_width    = width_q;
  assign bus.o_nbits    = nbits_q;
  assign bus.o_err      = err_q;
  assign bus.o_a        = mp_data[0];
  assign bus.o_prime    = mp_data[1];
  assign bus.o_Px       = mp_data[2];
  assign bus.o_Py       = mp_data[3];
  assign bus.o_m        = mp_data[4];
  assign bus.o_nPx      = np_data[0];
  assign bus.o_nPy      = np_data[1];

endmodule

// File: tb/tb_ecc_serial_loader.sv
// Bench for ecc_serial_loader: random operands
// serialized from a value-level model.
module tb_ecc_serial_loader;
  import ecc_serial_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [MAX_BITS-1:0] exp_mp [5];
  logic [MAX_BITS-1:0] exp_np [2];

  ecc_serial_loader_if bus();

  ecc_serial_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic int nb(input logic [1:0] w);
    return 16 << w;
  endfunction

  function automatic logic [127:0] rnd_val(input int n);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    if (n < 128) v = v & ((128'd1 << n) - 128'd1);
    return v;
  endfunction

  function automatic logic [127:0] dut_op(input int i);
    case (i)
      0:       return bus.o_a;
      1:       return bus.o_prime;
      2:       return bus.o_Px;
      3:       return bus.o_Py;
      4:       return bus.o_m;
      5:       return bus.o_nPx;
      default: return bus.o_nPy;
    endcase
  endfunction

  function automatic logic [127:0] exp_op(input int i);
    if (i < 5) return exp_mp[i];
    return exp_np[i-5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input logic [1:0] w);
    for (int i = 0; i < 5; i++) exp_mp[i] = rnd_val(nb(w));
    for (int i = 0; i < 2; i++) exp_np[i] = rnd_val(nb(w));
  endtask

  task automatic idle_inputs();
    bus.i_m_P_valid = 1'b0;
    bus.i_nP_valid  = 1'b0;
    bus.i_core_ack  = 1'b0;
    bus.i_mode      = rb();
    bus.i_a         = rb();
    bus.i_prime     = rb();
    bus.i_Px        = rb();
    bus.i_Py        = rb();
    bus.i_m         = rb();
    bus.i_nPx       = rb();
    bus.i_nPy       = rb();
  endtask

  // inputs for cycle c counted from the mP strobe
  task automatic drive_cycle(input int c, input logic [1:0] w,
                             input int d, input int bad);
    int n;
    n = nb(w);
    idle_inputs();
    bus.i_m_P_valid = (c == 0);
    if (c == 1) bus.i_mode = w[1];
    if (c == 2) bus.i_mode = w[0];
    if (c >= 3 && c < 3 + n) begin
      int k;
      k = n - 1 - (c - 3);
      bus.i_a     = exp_mp[0][k];
      bus.i_prime = exp_mp[1][k];
      bus.i_Px    = exp_mp[2][k];
      bus.i_Py    = exp_mp[3][k];
      bus.i_m     = exp_mp[4][k];
    end
    bus.i_nP_valid = (c == d) || (c == bad);
    if (c > d && c <= d + n) begin
      int k;
      k = n - 1 - (c - d - 1);
      bus.i_nPx = exp_np[0][k];
      bus.i_nPy = exp_np[1][k];
    end
  endtask

  task automatic run_load(input logic [1:0] w, input int d,
                          input int bad, output int first,
                          output int expc);
    int n;
    n = nb(w);
    expc = (n + 3 > d + n + 1) ? n + 3 : d + n + 1;
    first = -1;
    for (int c = 0; c < expc; c++) begin
      drive_cycle(c, w, d, bad);
      step();
      if (bus.o_op_valid && first < 0) first = c + 1;
    end
    idle_inputs();
  endtask

  task automatic do_ack();
    bus.i_core_ack = 1'b1;
    step();
    bus.i_core_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();
    checks++;
    if (bus.o_op_valid !== 1'b0 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got=%b%b exp=00",
               bus.o_op_valid, bus.o_err);
    end
    checks++;
    if (bus.o_width !== 2'b00 || bus.o_nbits !== '0) begin
      errors++;
      $display("FAIL rst_width got=%0d/%0d exp=0/0",
               bus.o_width, bus.o_nbits);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== '0) begin
        errors++;
        $display("FAIL rst_op%0d got=%h exp=0", i, dut_op(i));
      end
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_16bit();
    int first, expc;
    fill_random(2'b00);
    exp_mp[0] = 128'h0003;
    exp_mp[1] = 128'hFFF1;
    exp_mp[4] = 128'h00A5;
    run_load(2'b00, 10, -1, first, expc);
    checks++;
    if (first !== expc) begin
      errors++;
      $display("FAIL t16_lat got=%0d exp=%0d", first, expc);
    end
    checks++;
    if (bus.o_nbits !== CNT_W'(16) || bus.o_width !== 2'b00) begin
      errors++;
      $display("FAIL t16_width got=%0d/%0d exp=16/0",
               bus.o_nbits, bus.o_width);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL t16_op%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
    checks++;
    if (bus.o_op_valid !== 1'b0) begin
      errors++;
      $display("FAIL t16_ack got=%b exp=0", bus.o_op_valid);
    end
  endtask

  task automatic test_128bit();
    int first, expc;
    for (int i = 0; i < 5; i++) exp_mp[i] = '1;
    for (int i = 0; i < 2; i++) exp_np[i] = '1;
    run_load(2'b11, 3, -1, first, expc);
    checks++;
    if (first !== expc) begin
      errors++;
      $display("FAIL t128_lat got=%0d exp=%0d", first, expc);
    end
    checks++;
    if (bus.o_nbits !== CNT_W'(128)) begin
      errors++;
      $display("FAIL t128_nbits got=%0d exp=128", bus.o_nbits);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL t128_op%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
  endtask

  task automatic test_ack_hold();
    int first, expc, bad;
    fill_random(2'b00);
    run_load(2'b00, 3, -1, first, expc);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      idle_inputs();
      bus.i_m_P_valid = rb();
      bus.i_nP_valid  = rb();
      step();
      if (bus.o_op_valid !== 1'b1) bad++;
      for (int i = 0; i < 7; i++)
        if (dut_op(i) !== exp_op(i)) bad++;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable got=%0d exp=0 deviations", bad);
    end
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_err got=%b exp=0", bus.o_err);
    end
    do_ack();
    checks++;
    if (bus.o_op_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack got=%b exp=0", bus.o_op_valid);
    end
    fill_random(2'b01);
    run_load(2'b01, 5, -1, first, expc);
    checks++;
    if (first !== expc || bus.o_nbits !== CNT_W'(32)) begin
      errors++;
      $display("FAIL hold_t32 got=%0d/%0d exp=%0d/32",
               first, bus.o_nbits, expc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL hold_op%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
  endtask

  task automatic test_random();
    int first, expc, n, d;
    logic [1:0] w;
    for (int it = 0; it < 5; it++) begin
      w = 2'($urandom_range(3, 0));
      n = nb(w);
      d = $urandom_range(n + 4, 3);
      fill_random(w);
      run_load(w, d, -1, first, expc);
      checks++;
      if (first !== expc) begin
        errors++;
        $display("FAIL rnd%0d_lat got=%0d exp=%0d", it, first, expc);
      end
      checks++;
      if (bus.o_width !== w || bus.o_nbits !== CNT_W'(n)) begin
        errors++;
        $display("FAIL rnd%0d_width got=%0d/%0d exp=%0d/%0d",
                 it, bus.o_width, bus.o_nbits, w, n);
      end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (dut_op(i) !== exp_op(i)) begin
          errors++;
          $display("FAIL rnd%0d_op%0d got=%h exp=%h",
                   it, i, dut_op(i), exp_op(i));
        end
      end
      do_ack();
    end
  endtask

  task automatic test_err();
    int first, expc;
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got=%b exp=0", bus.o_err);
    end
    fill_random(2'b01);
    run_load(2'b01, 9, 1, first, expc);
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b exp=1", bus.o_err);
    end
    checks++;
    if (first !== expc) begin
      errors++;
      $display("FAIL err_lat got=%0d exp=%0d", first, expc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL err_op%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", bus.o_err);
    end
  endtask

  task automatic test_reset_mid();
    int first, expc;
    fill_random(2'b10);
    for (int c = 0; c < 23; c++) begin
      drive_cycle(c, 2'b10, 6, -1);
      step();
    end
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (bus.o_op_valid !== 1'b0 || bus.o_err !== 1'b0 ||
        bus.o_width !== 2'b00 || bus.o_nbits !== '0) begin
      errors++;
      $display("FAIL mid_rst_ctl got=%b%b/%0d/%0d exp=00/0/0",
               bus.o_op_valid, bus.o_err, bus.o_width, bus.o_nbits);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== '0) begin
        errors++;
        $display("FAIL mid_rst_op%0d got=%h exp=0", i, dut_op(i));
      end
    end
    step();
    rst = 1'b1;
    fill_random(2'b00);
    run_load(2'b00, 3, -1, first, expc);
    checks++;
    if (first !== expc || bus.o_nbits !== CNT_W'(16)) begin
      errors++;
      $display("FAIL mid_t16 got=%0d/%0d exp=%0d/16",
               first, bus.o_nbits, expc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL mid_op%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int first, expc;
    fill_random(2'b01);
    run_load(2'b01, 4, -1, first, expc);
    checks++;
    if (first !== expc) begin
      errors++;
      $display("FAIL b2b_lat32 got=%0d exp=%0d", first, expc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL b2b_op32_%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    bus.i_core_ack  = 1'b1;
    bus.i_m_P_valid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.o_op_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack got=%b exp=0", bus.o_op_valid);
    end
    fill_random(2'b10);
    run_load(2'b10, 3, -1, first, expc);
    checks++;
    if (first !== expc || bus.o_width !== 2'b10) begin
      errors++;
      $display("FAIL b2b_lat64 got=%0d/%0d exp=%0d/2",
               first, bus.o_width, expc);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_op(i) !== exp_op(i)) begin
        errors++;
        $display("FAIL b2b_op64_%0d got=%h exp=%h",
                 i, dut_op(i), exp_op(i));
      end
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_16bit();
    test_128bit();
    test_ack_hold();
    test_random();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
